// File: rtl/axi_ram_loader_pkg.sv
// Shared types and AXI constants for axi_ram_loader.
// With AXI_RAM_LOADER_VERIFY_EN defined, the read-back states are added to the state enum.
package axi_ram_loader_pkg;

`ifdef AXI_RAM_LOADER_VERIFY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_RESP,
        ST_RD_ADDR,
        ST_RD_DATA
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_RESP
    } state_t;
`endif

    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
    localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Strobe mask for the lowest `lanes` byte lanes; lanes == 8 gives 8'hFF.
    function automatic logic [7:0] lane_strb(input logic [3:0] lanes);
        logic [15:0] mask;
        mask = (16'd1 << lanes) - 16'd1;
        return mask[7:0];
    endfunction

endpackage

// File: rtl/axi_ram_loader.sv
// Packs a byte stream into 64-bit words and writes them to RAM over single-beat AXI writes.
// Optional read-back verification is enabled by defining AXI_RAM_LOADER_VERIFY_EN.
module axi_ram_loader
    import axi_ram_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter logic [31:0] MEM_SIZE  = 32'h10000,
    parameter int          ID_WIDTH  = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [7:0]          i_data,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic                i_flush,
    output logic                o_busy,
    output logic                o_full,
    output logic                o_err,
    output logic [31:0]         o_words,
    output logic [ID_WIDTH-1:0] o_awid,
    output logic [31:0]         o_awaddr,
    output logic [7:0]          o_awlen,
    output logic [2:0]          o_awsize,
    output logic [1:0]          o_awburst,
    output logic                o_awvalid,
    input  logic                i_awready,
    output logic [63:0]         o_wdata,
    output logic [7:0]          o_wstrb,
    output logic                o_wlast,
    output logic                o_wvalid,
    input  logic                i_wready,
    input  logic [ID_WIDTH-1:0] i_bid,
    input  logic [1:0]          i_bresp,
    input  logic                i_bvalid,
    output logic                o_bready,
    output logic [ID_WIDTH-1:0] o_arid,
    output logic [31:0]         o_araddr,
    output logic [7:0]          o_arlen,
    output logic [2:0]          o_arsize,
    output logic [1:0]          o_arburst,
    output logic                o_arvalid,
    input  logic                i_arready,
    input  logic [ID_WIDTH-1:0] i_rid,
    input  logic [63:0]         i_rdata,
    input  logic [1:0]          i_rresp,
    input  logic                i_rlast,
    input  logic                i_rvalid,
    output logic                o_rready,
    output logic                o_mismatch
);

    localparam logic [31:0] END_ADDR = BASE_ADDR + MEM_SIZE;

    state_t      state_q, state_d;
    logic [3:0]  lane_q, lane_d;
    logic [31:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wstrb_q, wstrb_d;
    logic        aw_pend_q, aw_pend_d;
    logic        w_pend_q, w_pend_d;
    logic [31:0] words_q, words_d;
    logic        err_q, err_d;
    logic        full_q, full_d;

    logic        accept;
    logic [3:0]  lane_n;
    logic        commit;

    assign o_ready = (state_q == ST_IDLE) && (lane_q < 4'd8) && !full_q;
    assign accept  = i_valid && o_ready;
    assign lane_n  = lane_q + {3'b000, accept};

`ifdef AXI_RAM_LOADER_VERIFY_EN
    logic mismatch_q, mismatch_d;
    logic rd_diff;

    always_comb begin
        rd_diff = 1'b0;
        for (int n = 0; n < 8; n++) begin
            if (wstrb_q[n] && (i_rdata[8*n +: 8] != wdata_q[8*n +: 8])) begin
                rd_diff = 1'b1;
            end
        end
    end
`endif

    // NOTE: every variable gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        words_d   = words_q;
        err_d     = err_q;
        full_d    = full_q;
        commit    = 1'b0;
`ifdef AXI_RAM_LOADER_VERIFY_EN
        mismatch_d = mismatch_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    wdata_d[{lane_q[2:0], 3'b000} +: 8] = i_data;
                    lane_d = lane_n;
                end
                // A flush in the same cycle as a byte includes that byte.
                if ((lane_n == 4'd8) || (i_flush && !full_q && (lane_n != 4'd0))) begin
                    state_d   = ST_ADDR;
                    wstrb_d   = lane_strb(lane_n);
                    aw_pend_d = 1'b1;
                    w_pend_d  = 1'b1;
                end
            end
            ST_ADDR: begin
                aw_pend_d = aw_pend_q && !i_awready;
                w_pend_d  = w_pend_q && !i_wready;
                if (!aw_pend_d && !w_pend_d) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (i_bvalid) begin
                    words_d = words_q + 32'd1;
                    if (i_bresp != AXI_RESP_OKAY) begin
                        err_d = 1'b1;
                    end
`ifdef AXI_RAM_LOADER_VERIFY_EN
                    state_d = ST_RD_ADDR;
`else
                    commit = 1'b1;
`endif
                end
            end
`ifdef AXI_RAM_LOADER_VERIFY_EN
            ST_RD_ADDR: begin
                if (i_arready) begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (i_rvalid) begin
                    if (rd_diff || (i_rresp != AXI_RESP_OKAY)) begin
                        mismatch_d = 1'b1;
                    end
                    commit = 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Word fully retired: move to the next slot and start packing afresh.
        if (commit) begin
            state_d = ST_IDLE;
            addr_d  = addr_q + 32'd8;
            lane_d  = 4'd0;
            wdata_d = '0;
            wstrb_d = '0;
            full_d  = ((addr_q + 32'd8) == END_ADDR);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            lane_q    <= 4'd0;
            addr_q    <= BASE_ADDR;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            words_q   <= '0;
            err_q     <= 1'b0;
            full_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            words_q   <= words_d;
            err_q     <= err_d;
            full_q    <= full_d;
        end
    end

    assign o_busy    = (state_q != ST_IDLE);
    assign o_full    = full_q;
    assign o_err     = err_q;
    assign o_words   = words_q;

    assign o_awid    = '0;
    assign o_awaddr  = addr_q;
    assign o_awlen   = AXI_LEN_SINGLE;
    assign o_awsize  = AXI_SIZE_8B;
    assign o_awburst = AXI_BURST_INCR;
    assign o_awvalid = (state_q == ST_ADDR) && aw_pend_q;
    assign o_wdata   = wdata_q;
    assign o_wstrb   = wstrb_q;
    assign o_wlast   = 1'b1;
    assign o_wvalid  = (state_q == ST_ADDR) && w_pend_q;
    assign o_bready  = (state_q == ST_RESP);

    assign o_arid    = '0;
    assign o_araddr  = addr_q;
    assign o_arlen   = AXI_LEN_SINGLE;
    assign o_arsize  = AXI_SIZE_8B;
    assign o_arburst = AXI_BURST_INCR;

`ifdef AXI_RAM_LOADER_VERIFY_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= mismatch_d;
        end
    end

    assign o_arvalid  = (state_q == ST_RD_ADDR);
    assign o_rready   = (state_q == ST_RD_DATA);
    assign o_mismatch = mismatch_q;

    logic unused_inputs;
    assign unused_inputs = ^{i_bid, i_rid, i_rlast};
`else
    assign o_arvalid  = 1'b0;
    assign o_rready   = 1'b1;
    assign o_mismatch = 1'b0;

    logic unused_inputs;
    assign unused_inputs = ^{i_bid, i_rid, i_rlast, i_rdata, i_rresp, i_rvalid, i_arready};
`endif

endmodule

// File: tb/tb_axi_ram_loader.sv
// Scoreboard bench for axi_ram_loader: the driver pushes expected AXI writes, an AXI slave model pops and compares.
// Read-back scenarios run only when AXI_RAM_LOADER_VERIFY_EN is defined.
module tb_axi_ram_loader;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] MSZ  = 32'h0000_0010;
    localparam int          IDW  = 4;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
    } exp_t;

    logic           i_clk = 1'b0;
    logic           i_rst = 1'b1;
    logic [7:0]     i_data = '0;
    logic           i_valid = 1'b0;
    logic           i_flush = 1'b0;
    logic           i_awready = 1'b0;
    logic           i_wready = 1'b0;
    logic [IDW-1:0] i_bid = '0;
    logic [1:0]     i_bresp = '0;
    logic           i_bvalid = 1'b0;
    logic           i_arready = 1'b0;
    logic [IDW-1:0] i_rid = '0;
    logic [63:0]    i_rdata = '0;
    logic [1:0]     i_rresp = '0;
    logic           i_rlast = 1'b1;
    logic           i_rvalid = 1'b0;

    logic           o_ready, o_busy, o_full, o_err, o_mismatch;
    logic [31:0]    o_words, o_awaddr, o_araddr;
    logic [IDW-1:0] o_awid, o_arid;
    logic [7:0]     o_awlen, o_arlen, o_wstrb;
    logic [2:0]     o_awsize, o_arsize;
    logic [1:0]     o_awburst, o_arburst;
    logic           o_awvalid, o_wlast, o_wvalid, o_bready, o_arvalid, o_rready;
    logic [63:0]    o_wdata;

    axi_ram_loader #(.BASE_ADDR(BASE), .MEM_SIZE(MSZ), .ID_WIDTH(IDW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
        .i_flush(i_flush), .o_busy(o_busy), .o_full(o_full), .o_err(o_err), .o_words(o_words),
        .o_awid(o_awid), .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize),
        .o_awburst(o_awburst), .o_awvalid(o_awvalid), .i_awready(i_awready),
        .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast), .o_wvalid(o_wvalid), .i_wready(i_wready),
        .i_bid(i_bid), .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready),
        .o_arid(o_arid), .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize),
        .o_arburst(o_arburst), .o_arvalid(o_arvalid), .i_arready(i_arready),
        .i_rid(i_rid), .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast), .i_rvalid(i_rvalid),
        .o_rready(o_rready), .o_mismatch(o_mismatch)
    );

    always #5 i_clk = ~i_clk;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model and scoreboard
    exp_t        sb[$];
    logic [31:0] mdl_addr = BASE;
    logic [63:0] mdl_data = '0;
    int          mdl_lane = 0;
    bit          mdl_full = 1'b0;
    int          mdl_words = 0;

    // Slave model configuration and observations
    int          aw_delay = 0, w_delay = 0;
    logic [1:0]  bresp_cfg = 2'b00;
    bit          rd_corrupt = 1'b0;
    int          aw_cyc = 0, w_cyc = 0;
    bit          aw_seen = 1'b0, w_seen = 1'b0, r_pend = 1'b0;
    logic [31:0] aw_first, seen_awaddr, last_aw_addr;
    logic [63:0] w_first, seen_wdata, last_w_data;
    logic [7:0]  seen_wstrb, last_w_strb;
    bit          unstable = 1'b0;
    int          last_aw_cyc = 0, last_w_cyc = 0;
    int          aw_total = 0, b_total = 0;

    always @(negedge i_clk) begin
        if (i_rst) begin
            i_awready = 0; i_wready = 0; i_bvalid = 0; i_arready = 0; i_rvalid = 0;
            aw_cyc = 0; w_cyc = 0; aw_seen = 0; w_seen = 0; r_pend = 0;
        end else begin
            if (o_awvalid) begin
                if (aw_cyc == 0) aw_first = o_awaddr;
                else if (o_awaddr !== aw_first) unstable = 1'b1;
                aw_cyc++;
                i_awready = (aw_cyc > aw_delay);
                if (i_awready) begin
                    aw_seen = 1'b1;
                    seen_awaddr = o_awaddr;
                    aw_total++;
                    check("awlen", o_awlen, 8'd0);
                    check("awsize", o_awsize, 3'd3);
                    check("awburst", o_awburst, 2'b01);
                    check("awid", o_awid, '0);
                end
            end else begin
                i_awready = 1'b0;
            end

            if (o_wvalid) begin
                if (w_cyc == 0) w_first = o_wdata;
                else if (o_wdata !== w_first) unstable = 1'b1;
                w_cyc++;
                i_wready = (w_cyc > w_delay);
                if (i_wready) begin
                    w_seen = 1'b1;
                    seen_wdata = o_wdata;
                    seen_wstrb = o_wstrb;
                    check("wlast", o_wlast, 1'b1);
                end
            end else begin
                i_wready = 1'b0;
            end

            if (aw_seen && w_seen) begin
                if (sb.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_awaddr", seen_awaddr, e.addr);
                    check("sb_wdata", seen_wdata, e.data);
                    check("sb_wstrb", seen_wstrb, e.strb);
                end
                last_aw_addr = seen_awaddr;
                last_w_data  = seen_wdata;
                last_w_strb  = seen_wstrb;
                last_aw_cyc  = aw_cyc;
                last_w_cyc   = w_cyc;
                aw_cyc = 0; w_cyc = 0; aw_seen = 0; w_seen = 0;
            end

            if (o_bready) begin
                i_bvalid = 1'b1;
                i_bresp  = bresp_cfg;
                b_total++;
            end else begin
                i_bvalid = 1'b0;
            end

            if (r_pend && o_rready) begin
                i_rvalid = 1'b1;
                i_rresp  = 2'b00;
                i_rdata  = last_w_data ^ (rd_corrupt ? 64'h1 : 64'h0);
                r_pend   = 1'b0;
            end else begin
                i_rvalid = 1'b0;
            end

            i_arready = o_arvalid;
            if (o_arvalid) begin
                r_pend = 1'b1;
                check("araddr", o_araddr, last_aw_addr);
            end
        end
    end

    task automatic push_word();
        exp_t e;
        e.addr = mdl_addr;
        e.data = mdl_data;
        e.strb = 8'hFF >> (8 - mdl_lane);
        sb.push_back(e);
        mdl_addr  = mdl_addr + 32'd8;
        mdl_data  = '0;
        mdl_lane  = 0;
        mdl_words++;
        mdl_full  = (mdl_addr == BASE + MSZ);
    endtask

    task automatic do_reset();
        i_rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0;
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
        sb.delete();
        mdl_addr = BASE; mdl_data = '0; mdl_lane = 0; mdl_full = 1'b0; mdl_words = 0;
        bresp_cfg = 2'b00; aw_delay = 0; w_delay = 0; rd_corrupt = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit flush);
        int n;
        n = 0;
        @(negedge i_clk);
        i_valid = 1'b1;
        i_data  = b;
        while (!o_ready && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 200) begin
            check("ready_timeout", 1, 0);
        end else begin
            i_flush = flush;
            mdl_data[mdl_lane*8 +: 8] = b;
            mdl_lane++;
            if (mdl_lane == 8 || flush) push_word();
        end
        @(posedge i_clk);
        #1 i_valid = 1'b0; i_flush = 1'b0;
    endtask

    task automatic flush_pulse();
        @(negedge i_clk);
        i_flush = 1'b1;
        if (mdl_lane > 0 && !mdl_full) push_word();
        @(posedge i_clk);
        #1 i_flush = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge i_clk);
        while (o_busy && n < 500) begin
            @(negedge i_clk);
            n++;
        end
        check({tag, "_idle_in_time"}, (n < 500), 1'b1);
        check({tag, "_sb_drained"}, sb.size(), 0);
        check({tag, "_words"}, o_words, mdl_words);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int aw_before;
        do_reset();

        // Reset state
        @(negedge i_clk);
        check("rst_ready", o_ready, 1'b1);
        check("rst_busy", o_busy, 1'b0);
        check("rst_awvalid", o_awvalid, 1'b0);
        check("rst_wvalid", o_wvalid, 1'b0);
        check("rst_bready", o_bready, 1'b0);
        check("rst_arvalid", o_arvalid, 1'b0);
        check("rst_words", o_words, 32'd0);
        check("rst_err", o_err, 1'b0);
        check("rst_full", o_full, 1'b0);
        check("rst_mismatch", o_mismatch, 1'b0);
        check("rst_wdata", o_wdata, 64'd0);
`ifdef AXI_RAM_LOADER_VERIFY_EN
        check("rst_rready", o_rready, 1'b0);
`else
        check("rst_rready", o_rready, 1'b1);
`endif

        // Eight bytes form one full word
        for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
        wait_idle("full_word");
        check("full_word_addr", last_aw_addr, BASE);
        check("full_word_data", last_w_data, 64'h0807060504030201);
        check("full_word_strb", last_w_strb, 8'hFF);
        check("full_word_words", o_words, 32'd1);

        // Late AWREADY with immediate WREADY
        do_reset();
        aw_delay = 3;
        unstable = 1'b0;
        b0 = b_total;
        for (int i = 0; i < 8; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
        wait_idle("late_aw");
        check("late_aw_wvalid_cycles", last_w_cyc, 1);
        check("late_aw_awvalid_cycles", last_aw_cyc, 4);
        check("late_aw_stable", unstable, 1'b0);
        check("late_aw_b_cycles", b_total - b0, 1);

        // Partial word flushed together with its last byte, then a flush-only word
        do_reset();
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b1);
        wait_idle("flush3");
        check("flush3_data", last_w_data, 64'h0000_0000_00CC_BBAA);
        check("flush3_strb", last_w_strb, 8'h07);
        flush_pulse();
        @(negedge i_clk);
        check("flush_empty_noop", o_busy, 1'b0);
        send_byte(8'h11, 1'b0);
        flush_pulse();
        wait_idle("flush1");
        check("flush1_addr", last_aw_addr, BASE + 32'd8);
        check("flush1_data", last_w_data, 64'h11);
        check("flush1_strb", last_w_strb, 8'h01);

        // Error response is sticky and loading continues
        do_reset();
        bresp_cfg = 2'b10;
        for (int i = 0; i < 8; i++) send_byte(8'(8'h20 + i), 1'b0);
        wait_idle("err0");
        check("err_set", o_err, 1'b1);
        bresp_cfg = 2'b00;
        for (int i = 0; i < 8; i++) send_byte(8'(8'h40 + i), 1'b0);
        wait_idle("err1");
        check("err_sticky", o_err, 1'b1);
        check("err_word1_addr", last_aw_addr, BASE + 32'd8);

        // Window exhausted after two words
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(8'h80 + i), 1'b0);
            if (i == 7) check("full_not_early", o_full, 1'b0);
        end
        wait_idle("window");
        check("window_full", o_full, 1'b1);
        check("window_ready", o_ready, 1'b0);
        aw_before = aw_total;
        for (int i = 0; i < 8; i++) begin
            @(negedge i_clk);
            i_valid = 1'b1;
            i_data  = 8'(8'hE0 + i);
            check("window_reject", o_ready, 1'b0);
        end
        i_flush = 1'b1;
        @(negedge i_clk);
        i_flush = 1'b0;
        i_valid = 1'b0;
        repeat (10) @(negedge i_clk);
        check("window_no_busy", o_busy, 1'b0);
        check("window_no_aw", aw_total - aw_before, 0);
        check("window_words", o_words, 32'd2);

`ifdef AXI_RAM_LOADER_VERIFY_EN
        // Read-back: matching data keeps o_mismatch low, corrupted byte 0 sets it
        do_reset();
        for (int i = 0; i < 8; i++) send_byte(8'(8'h50 + i), 1'b0);
        wait_idle("rb_ok");
        check("rb_ok_mismatch", o_mismatch, 1'b0);
        rd_corrupt = 1'b1;
        for (int i = 0; i < 8; i++) send_byte(8'(8'h60 + i), 1'b0);
        wait_idle("rb_bad");
        check("rb_bad_mismatch", o_mismatch, 1'b1);
        check("rb_full", o_full, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
